bcd_scan_counter: RTL and testbench



---
 rtl/bcd_scan_counter_pkg.sv | 36 +++
 rtl/bcd_scan_counter_if.sv | 16 +
 rtl/bcd_scan_counter_bin2bcd_seq.sv | 70 +++++++
 rtl/bcd_scan_counter.sv | 112 +++++++++++
 tb/tb_bcd_scan_counter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants, conversion-state enum and the double-dabble adjust step
// used by the BCD scan counter.
package bcd_scan_pkg;

  localparam int COUNT_W    = 9;
  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 3;
  localparam int SCRATCH_W  = BCD_W * NUM_DIGITS;

  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t DIG_ONES     = 2'd0;
  localparam digit_idx_t DIG_TENS     = 2'd1;
  localparam digit_idx_t DIG_HUNDREDS = 2'd2;

  // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [SCRATCH_W-1:0] dabble_adjust(input logic [SCRATCH_W-1:0] s);
    logic [SCRATCH_W-1:0] r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[i*BCD_W +: BCD_W] >= 4'd5) begin
        r[i*BCD_W +: BCD_W] = s[i*BCD_W +: BCD_W] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the BCD scan counter; the controller side is
// the master, the counter itself the slave.
interface bcd_scan_counter_if;
  import bcd_scan_pkg::*;

  logic                  en;
  logic                  clr;
  logic [COUNT_W-1:0]    count;
  logic [BCD_W-1:0]      bcd;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  busy;

  modport master (output en, clr, input count, bcd, digit_sel, busy);
  modport slave  (input en, clr, output count, bcd, digit_sel, busy);

endinterface

// File: rtl/bcd_scan_counter_bin2bcd_seq.sv
// Sequential double-dabble converter: restarts itself whenever bin differs
// from the last snapshot; digits are valid while done is high.
module bin2bcd_seq
  import bcd_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] bin,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   hundreds,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   ones
);

  conv_state_t          state, state_next;
  logic [COUNT_W-1:0]   snap;
  logic [COUNT_W-1:0]   work;
  logic [SCRATCH_W-1:0] scratch;
  logic [3:0]           iter;
  logic                 launch;

  // snap keeps the converted value for change detection; work is the copy
  // that gets shifted out.
  assign launch = (state == IDLE) && start && (bin != snap);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first keeps this block free of latches on
  // paths that do not change the state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = SHIFT;
      SHIFT:   if (iter == 4'd1) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      work    <= '0;
      scratch <= '0;
      iter    <= '0;
    end else if (launch) begin
      snap    <= bin;
      work    <= bin;
      scratch <= '0;
      iter    <= 4'd9;
    end else if (state == SHIFT) begin
      {scratch, work} <= {dabble_adjust(scratch), work} << 1;
      iter            <= iter - 4'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == COMMIT);
  assign hundreds = scratch[3*BCD_W-1 -: BCD_W];
  assign tens     = scratch[2*BCD_W-1 -: BCD_W];
  assign ones     = scratch[BCD_W-1   -: BCD_W];

endmodule

// File: rtl/bcd_scan_counter.sv
// Paced 9-bit up counter with BCD conversion and three-digit scan output.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits with BLANK_CODE.
module bcd_scan_counter
  import bcd_scan_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input logic               clk,
  input logic               rst,
  bcd_scan_counter_if.slave bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic [COUNT_W-1:0]    count;
  logic [SCAN_W-1:0]     scan_cnt;
  logic                  scan_wrap;
  digit_idx_t            digit_idx, idx_next;
  logic [BCD_W-1:0]      hund_q, tens_q, ones_q;
  logic [BCD_W-1:0]      conv_h, conv_t, conv_o;
  logic [BCD_W-1:0]      code_next;
  logic [BCD_W-1:0]      bcd_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  conv_done;

  assign tick = bus.en && (tick_cnt == TICK_LAST);

  // clr has priority over tick and works regardless of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      count    <= '0;
    end else if (bus.clr) begin
      tick_cnt <= '0;
      count    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      count    <= count + 1'b1;
    end else if (bus.en) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  bin2bcd_seq u_conv (
    .clk      (clk),
    .rst      (rst),
    .bin      (count),
    .start    (1'b1),
    .busy     (bus.busy),
    .done     (conv_done),
    .hundreds (conv_h),
    .tens     (conv_t),
    .ones     (conv_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hund_q <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else if (conv_done) begin
      hund_q <= conv_h;
      tens_q <= conv_t;
      ones_q <= conv_o;
    end
  end

  assign scan_wrap = (scan_cnt == SCAN_LAST);

  always_comb begin
    idx_next = digit_idx;
    if (scan_wrap) idx_next = (digit_idx == DIG_HUNDREDS) ? DIG_ONES : digit_idx + 2'd1;
  end

  always_comb begin
    case (idx_next)
      DIG_TENS:     code_next = tens_q;
      DIG_HUNDREDS: code_next = hund_q;
      default:      code_next = ones_q;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_next == DIG_HUNDREDS && hund_q == '0) code_next = BLANK_CODE;
    if (idx_next == DIG_TENS && hund_q == '0 && tens_q == '0) code_next = BLANK_CODE;
`endif
  end

  // bcd and digit_sel come from the same next index so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= DIG_ONES;
      sel_q     <= NUM_DIGITS'(1);
      bcd_q     <= '0;
    end else begin
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      digit_idx <= idx_next;
      sel_q     <= NUM_DIGITS'(1) << idx_next;
      bcd_q     <= code_next;
    end
  end

  assign bus.count     = count;
  assign bus.bcd       = bcd_q;
  assign bus.digit_sel = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: two instances (16/2 and 12/3 dividers) checked
// every cycle against an arithmetic model, plus directed literal checks.
module tb_bcd_scan_counter;
  import bcd_scan_pkg::*;

  localparam int TD_A = 16, SD_A = 2;
  localparam int TD_B = 12, SD_B = 3;
`ifdef LEADING_ZERO_BLANK_EN
  localparam int BLANK_ON = 1;
`else
  localparam int BLANK_ON = 0;
`endif
  localparam int HZ = BLANK_ON ? 15 : 0;  // shown for a leading-zero digit

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_scan_counter_if bus_a();
  bcd_scan_counter_if bus_b();

  bcd_scan_counter #(.TICK_DIV(TD_A), .SCAN_DIV(SD_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  bcd_scan_counter #(.TICK_DIV(TD_B), .SCAN_DIV(SD_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int tick; int count; int snap; int timer; int disp;
    int idx;  int scan;  int bcd;  int sel;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m = '{default: 0};
    m.sel = 1;
    return m;
  endfunction

  function automatic int digit_of(input int v, input int idx);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (BLANK_ON != 0 && idx == 2 && h == 0) return 15;
    if (BLANK_ON != 0 && idx == 1 && h == 0 && t == 0) return 15;
    return (idx == 2) ? h : (idx == 1) ? t : o;
  endfunction

  // Conversion modelled as a 10-cycle busy window; display updates when it ends.
  function automatic model_t model_step(input model_t m, input bit en, input bit clr,
                                        input int td, input int sd);
    model_t n;
    int ni;
    n  = m;
    ni = (m.scan == sd - 1) ? (m.idx + 1) % 3 : m.idx;
    n.scan = (m.scan == sd - 1) ? 0 : m.scan + 1;
    n.idx  = ni;
    n.sel  = 1 << ni;
    n.bcd  = digit_of(m.disp, ni);
    if (m.timer == 0) begin
      if (m.count != m.snap) begin
        n.snap  = m.count;
        n.timer = 10;
      end
    end else begin
      n.timer = m.timer - 1;
      if (n.timer == 0) n.disp = m.snap;
    end
    if (clr) begin
      n.count = 0;
      n.tick  = 0;
    end else if (en) begin
      if (m.tick == td - 1) begin
        n.tick  = 0;
        n.count = (m.count + 1) % 512;
      end else begin
        n.tick = m.tick + 1;
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma  <= model_reset();
      mb  <= model_reset();
      cyc <= 0;
    end else begin
      ma  <= model_step(ma, bus_a.en, bus_a.clr, TD_A, SD_A);
      mb  <= model_step(mb, bus_b.en, bus_b.clr, TD_B, SD_B);
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("a_count", bus_a.count,     ma.count);
      check("a_bcd",   bus_a.bcd,       ma.bcd);
      check("a_sel",   bus_a.digit_sel, ma.sel);
      check("a_busy",  bus_a.busy,      ma.timer != 0);
      check("b_count", bus_b.count,     mb.count);
      check("b_bcd",   bus_b.bcd,       mb.bcd);
      check("b_sel",   bus_b.digit_sel, mb.sel);
      check("b_busy",  bus_b.busy,      mb.timer != 0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic run_b_to(input int target);
    bit found = 0;
    bus_b.en = 1'b1;
    for (int k = 0; k < 7000 && !found; k++) begin
      @(negedge clk);
      if (bus_b.count == target) found = 1;
    end
    bus_b.en = 1'b0;
    check("b_reach_count", found, 1);
  endtask

  task automatic pulse_clr_b();
    bus_b.clr = 1'b1;
    @(negedge clk);
    bus_b.clr = 1'b0;
  endtask

  // Let the conversion settle, then check one full ones/tens/hundreds scan.
  task automatic check_scan_b(input string name, input int h, input int t, input int o);
    logic [2:0] prev;
    bit found = 0;
    repeat (15) @(negedge clk);
    prev = bus_b.digit_sel;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (prev == 3'b100 && bus_b.digit_sel == 3'b001) found = 1;
      else prev = bus_b.digit_sel;
    end
    check({name, "_phase"}, found, 1);
    for (int i = 0; i < 9; i++) begin
      check({name, "_sel"}, bus_b.digit_sel, 1 << (i / 3));
      check({name, "_bcd"}, bus_b.bcd, (i < 3) ? o : (i < 6) ? t : h);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rises, highs;
    bit prev_busy, found;
    rst = 1'b1;
    bus_a.en = 1'b1; bus_a.clr = 1'b0;
    bus_b.en = 1'b1; bus_b.clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_sel",   bus_a.digit_sel, 3'b001);
    check("rst_a_bcd",   bus_a.bcd,       0);
    check("rst_a_count", bus_a.count,     0);
    check("rst_a_busy",  bus_a.busy,      0);
    check("rst_b_sel",   bus_b.digit_sel, 3'b001);
    check("rst_b_count", bus_b.count,     0);
    rst = 1'b0;

    // First tick, conversion start and display on dut_a (TICK_DIV=16, SCAN_DIV=2).
    wait_cyc(15); check("t1_count_c15", bus_a.count, 0);
    wait_cyc(16); check("t1_count_c16", bus_a.count, 1); check("t1_busy_c16", bus_a.busy, 0);
    wait_cyc(17); check("t1_busy_c17", bus_a.busy, 1);
    wait_cyc(24); check("t1_sel_c24", bus_a.digit_sel, 3'b001); check("t1_bcd_c24", bus_a.bcd, 0);
    wait_cyc(26); check("t1_busy_c26", bus_a.busy, 1);
    wait_cyc(27); check("t1_busy_c27", bus_a.busy, 0);
    wait_cyc(30); check("t1_sel_c30", bus_a.digit_sel, 3'b001); check("t1_bcd_c30", bus_a.bcd, 1);

    // Steady 305 on dut_b (SCAN_DIV=3).
    run_b_to(305);
    check_scan_b("t5_305", 3, 0, 5);

    // Leading-zero handling.
    pulse_clr_b();
    check("t6_clr", bus_b.count, 0);
    run_b_to(7);
    check_scan_b("t6_007", HZ, HZ, 7);
    run_b_to(40);
    check_scan_b("t6_040", HZ, 4, 0);

    // clr on the same edge as a tick at count 42.
    run_b_to(42);
    bus_b.en = 1'b1;
    repeat (11) @(negedge clk);
    check("t3_pre", bus_b.count, 42);
    bus_b.clr = 1'b1;
    @(negedge clk);
    bus_b.clr = 1'b0;
    bus_b.en  = 1'b0;
    check("t3_count", bus_b.count, 0);
    check_scan_b("t3_000", HZ, HZ, 0);

    // Count changes mid-SHIFT: two back-to-back conversions.
    run_b_to(5);
    repeat (4) @(negedge clk);
    check("t4_busy_mid", bus_b.busy, 1);
    pulse_clr_b();
    rises = 0; highs = 0; prev_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus_b.busy && !prev_busy) rises++;
      if (bus_b.busy) highs++;
      prev_busy = bus_b.busy;
      @(negedge clk);
    end
    check("t4_rises", rises, 2);
    check("t4_highs", highs, 16);
    check_scan_b("t4_000", HZ, HZ, 0);

    // Top of range and wrap.
    run_b_to(511);
    check_scan_b("t2_511", 5, 1, 1);
    run_b_to(0);
    check_scan_b("t2_wrap", HZ, HZ, 0);

    // Reset in the middle of a conversion.
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus_a.busy) found = 1;
    end
    check("rmid_found_busy", found, 1);
    rst = 1'b1;
    #1;
    check("rmid_busy_async", bus_a.busy, 0);
    check("rmid_count_async", bus_a.count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("rmid_a_idle", bus_a.busy, 0);
      check("rmid_b_idle", bus_b.busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
